// File: rtl/iseq_host_bridge.sv
// Host-side bridge for softMC: feeds host instruction words over app_en/app_ack,
// keeps one sequence in flight, and streams readback FIFO entries out as 32-bit words.
module iseq_host_bridge #(
  parameter int DQ_WIDTH      = 64,
  parameter int START_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_rx_valid,
  output logic                  host_rx_ready,
  input  logic [31:0]           host_rx_data,
  input  logic                  host_rx_last,
  output logic                  app_en,
  input  logic                  app_ack,
  output logic [31:0]           app_instr,
  input  logic                  iq_full,
  input  logic                  processing_iseq,
  input  logic                  rdback_fifo_empty,
  output logic                  rdback_fifo_rden,
  input  logic [DQ_WIDTH*4-1:0] rdback_data,
  output logic                  host_tx_valid,
  input  logic                  host_tx_ready,
  output logic [31:0]           host_tx_data,
  output logic                  busy,
  output logic                  timeout_err
);
  localparam int RD_W  = DQ_WIDTH * 4;
  localparam int NW    = RD_W / 32;
  localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
  localparam int CNT_W = 17;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NW - 1);

  typedef enum logic [1:0] {ACCEPT, WAIT_START, WAIT_DONE} state_e;

  state_e            state_q, state_d;
  logic              hold_valid_q, hold_valid_d;
  logic              hold_last_q, hold_last_d;
  logic [31:0]       app_instr_q, app_instr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RD_W-1:0]   buf_q, buf_d;
  logic              buf_valid_q, buf_valid_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NW-1:0][31:0] buf_words;
  logic              rx_hs, ack_hs, tx_hs;

  // Ready and pop are gated by reset so every output reads 0 while rst is held.
  assign host_rx_ready    = ~rst & (state_q == ACCEPT) & ~hold_valid_q & ~iq_full;
  assign rx_hs            = host_rx_valid & host_rx_ready;
  assign ack_hs           = hold_valid_q & app_ack;
  assign app_en           = hold_valid_q;
  assign app_instr        = app_instr_q;
  assign rdback_fifo_rden = ~rst & ~buf_valid_q & ~rdback_fifo_empty;
  assign tx_hs            = buf_valid_q & host_tx_ready;
  assign host_tx_valid    = buf_valid_q;
  assign buf_words        = buf_q;
  assign host_tx_data     = buf_words[idx_q];
  assign busy             = (state_q != ACCEPT) | hold_valid_q | buf_valid_q;

  always_comb begin
    state_d      = state_q;
    hold_valid_d = hold_valid_q;
    hold_last_d  = hold_last_q;
    app_instr_d  = app_instr_q;
    cnt_d        = cnt_q;
    timeout_err  = 1'b0;
    if (rx_hs) begin
      app_instr_d  = host_rx_data;
      hold_last_d  = host_rx_last;
      hold_valid_d = 1'b1;
    end
    if (ack_hs) hold_valid_d = 1'b0;
    case (state_q)
      ACCEPT: begin
        if (ack_hs && hold_last_q) begin
          state_d = WAIT_START;
          cnt_d   = '0;
        end
      end
      WAIT_START: begin
        // A start seen on the final timeout cycle still wins over the error.
        if (processing_iseq) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_err = 1'b1;
          state_d     = ACCEPT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: if (!processing_iseq) state_d = ACCEPT;
      default:   state_d = ACCEPT;
    endcase
  end

  always_comb begin
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    idx_d       = idx_q;
    if (rdback_fifo_rden) begin
      buf_d       = rdback_data;
      buf_valid_d = 1'b1;
      idx_d       = '0;
    end else if (tx_hs) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == IDX_LAST) buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ACCEPT;
      hold_valid_q <= 1'b0;
      hold_last_q  <= 1'b0;
      app_instr_q  <= '0;
      cnt_q        <= '0;
      buf_q        <= '0;
      buf_valid_q  <= 1'b0;
      idx_q        <= '0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      hold_last_q  <= hold_last_d;
      app_instr_q  <= app_instr_d;
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      buf_valid_q  <= buf_valid_d;
      idx_q        <= idx_d;
    end
  end
endmodule
